// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment shift-chain sequencer.
// Optional feature macro: AUTO_REFRESH_EN (periodic frame restart).
package seg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        DONE     = 3'd4
    } seg_state_e;

    localparam int SEG_FRAME_W     = 64;
    localparam int SEG_CNT_W       = $clog2(SEG_FRAME_W);
    localparam int SEG_DIV_DEF     = 2;
    localparam int SEG_REFRESH_DEF = 50000;
    // Divider count width; covers the full legal DIV range 1..255.
    localparam int SEG_DIV_W       = 8;

endpackage

// File: rtl/seg_tick_gen.sv
// Serial-clock divider: counts 0..DIV-1 inside each timed state and
// flags the last cycle with a one-cycle tick. The count restarts on
// every state change so each timed state lasts exactly DIV cycles.
module seg_tick_gen
    import seg_pkg::*;
#(
    parameter int DIV = SEG_DIV_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [SEG_DIV_W-1:0] LAST = SEG_DIV_W'(DIV - 1);

    logic [SEG_DIV_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Divider count, held at zero outside timed states.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr || !en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seg_shift_ctrl.sv
// Segment-image serialiser: captures a WIDTH-bit frame on request,
// shifts it MSB-first with a divided serial clock, strobes the latch,
// then pulses done. All outputs come straight from flops, so they lag
// the FSM state by one cycle.
// Optional feature macro: AUTO_REFRESH_EN -- a free-running counter
// starts a frame every REFRESH cycles when the FSM is idle.
module seg_shift_ctrl
    import seg_pkg::*;
#(
    parameter int WIDTH   = SEG_FRAME_W,
    parameter int DIV     = SEG_DIV_DEF,
    parameter int REFRESH = SEG_REFRESH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] seg_txt,
    output logic             busy,
    output logic             done,
    output logic             s_clk,
    output logic             s_data,
    output logic             s_latch
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Reject illegal configurations at elaboration time.
    if (DIV < 1 || DIV > 255 || REFRESH < 1 || WIDTH < 1) begin : g_param_chk
        $error("seg_shift_ctrl: illegal parameter value");
    end

    seg_state_e       state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             req, accept, timed, state_chg, tick;
    logic             busy_d, done_d, s_clk_d, s_data_d, s_latch_d;

`ifdef AUTO_REFRESH_EN
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    logic [RW-1:0] ref_cnt;
    logic          ref_wrap;

    assign ref_wrap = (ref_cnt == RW'(REFRESH - 1));

    // Free-running refresh counter; a wrap acts like a start pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ref_cnt <= '0;
        else if (ref_wrap)
            ref_cnt <= '0;
        else
            ref_cnt <= ref_cnt + 1'b1;
    end

    // Coincident auto and external requests collapse into one frame;
    // a wrap outside IDLE is simply lost.
    assign req = start | ref_wrap;
`else
    assign req = start;
`endif

    // Requests are honoured only in IDLE, so anything arriving during a
    // frame or in its DONE cycle is dropped rather than queued.
    assign accept    = (state == IDLE) && req;
    assign timed     = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH);
    assign state_chg = (state_nxt != state);

    seg_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .en   (timed),
        .clr  (state_chg),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; timed states advance only on the divider tick.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (accept) state_nxt = SHIFT_LO;
            SHIFT_LO: if (tick)   state_nxt = SHIFT_HI;
            SHIFT_HI: if (tick)   state_nxt = (bit_cnt == '0) ? LATCH : SHIFT_LO;
            LATCH:    if (tick)   state_nxt = DONE;
            DONE:                 state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Frame capture and MSB-first shifting at the end of each high phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shreg   <= seg_txt;
            bit_cnt <= CW'(WIDTH - 1);
        end else if (state == SHIFT_HI && tick && bit_cnt != '0) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    // Output decode from the current state.
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        s_clk_d   = 1'b0;
        s_data_d  = 1'b0;
        s_latch_d = 1'b0;
        unique case (state)
            SHIFT_LO: begin
                busy_d   = 1'b1;
                s_data_d = shreg[WIDTH-1];
            end
            SHIFT_HI: begin
                busy_d   = 1'b1;
                s_clk_d  = 1'b1;
                s_data_d = shreg[WIDTH-1];
            end
            LATCH: begin
                busy_d    = 1'b1;
                s_latch_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers; a reset clears everything at once, abandoning
    // any frame in flight without latch or done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            s_clk   <= 1'b0;
            s_data  <= 1'b0;
            s_latch <= 1'b0;
        end else begin
            busy    <= busy_d;
            done    <= done_d;
            s_clk   <= s_clk_d;
            s_data  <= s_data_d;
            s_latch <= s_latch_d;
        end
    end

endmodule
